// File: rtl/bcd_display_scheduler.sv
// Round-robin sharing of one external binary-to-BCD converter plus a multiplexed digit scan.
// Optional macro LEADING_ZERO_BLANK_EN enables leading-zero blanking of hundreds/tens digits.
module bcd_display_scheduler #(
   parameter int NUM_CH   = 2,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [8*NUM_CH-1:0]   val_flat,
   input  logic [NUM_CH-1:0]     upd_req,
   output logic [NUM_CH-1:0]     upd_ack,
   output logic [7:0]            conv_bin,
   input  logic [3:0]            conv_f,
   input  logic [3:0]            conv_s,
   input  logic [3:0]            conv_t,
   output logic [3*NUM_CH-1:0]   an_n,
   output logic [3:0]            seg_bcd,
   output logic                  blank
);

   localparam int NUM_DIG = 3 * NUM_CH;
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DIG_W   = $clog2(NUM_DIG);
   localparam int PS_W    = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;

   state_t              state;
   logic [NUM_CH-1:0]   pending;
   logic [CH_W-1:0]     rr_ptr;
   logic [NUM_CH-1:0]   req_all;
   logic [NUM_CH-1:0]   cap_vec;
   logic [CH_W-1:0]     grant_nxt;
   logic [3:0]          digit [NUM_DIG];
   logic [PS_W-1:0]     prescaler;
   logic [DIG_W-1:0]    scan_idx;
   logic [DIG_W-1:0]    scan_nxt;
   logic [DIG_W-1:0]    shown_idx;
   logic                tick;

   // First requesting channel strictly after ptr, wrapping; ptr itself has lowest priority.
   function automatic logic [CH_W-1:0] next_grant(input logic [NUM_CH-1:0] req,
                                                  input logic [CH_W-1:0]   ptr);
      logic [CH_W-1:0] sel;
      int              c;
      sel = ptr;
      for (int k = NUM_CH; k >= 1; k--) begin
         c = (int'(ptr) + k) % NUM_CH;
         if (req[c]) sel = CH_W'(c);
      end
      return sel;
   endfunction

   always_comb begin
      req_all   = pending | upd_req;
      grant_nxt = next_grant(req_all, rr_ptr);
      cap_vec   = '0;
      if (state == CAPTURE) cap_vec[rr_ptr] = 1'b1;
   end

   // Scheduler: grant -> settle -> capture. rr_ptr doubles as the active grant index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         rr_ptr   <= CH_W'(NUM_CH - 1);
         conv_bin <= '0;
         upd_ack  <= '0;
      end else begin
         pending <= (pending & ~cap_vec) | upd_req;
         upd_ack <= cap_vec;
         case (state)
            IDLE: begin
               if (|req_all) begin
                  rr_ptr   <= grant_nxt;
                  conv_bin <= val_flat[8*grant_nxt +: 8];
                  state    <= DRIVE;
               end
            end
            DRIVE:   state <= CAPTURE;
            CAPTURE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIG; i++) digit[i] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (state == CAPTURE && int'(rr_ptr) == c) begin
               digit[3*c]     <= conv_t;
               digit[3*c + 1] <= conv_s;
               digit[3*c + 2] <= conv_f;
            end
         end
      end
   end

   always_comb begin
      tick      = (prescaler == PS_W'(SCAN_DIV - 1));
      scan_nxt  = (scan_idx == DIG_W'(NUM_DIG - 1)) ? '0 : scan_idx + DIG_W'(1);
      shown_idx = tick ? scan_nxt : scan_idx;
   end

   // Display scan: seg_bcd follows the shown digit every cycle so captures appear without a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         scan_idx  <= '0;
         an_n      <= '1;
         seg_bcd   <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PS_W'(1);
         if (tick) begin
            scan_idx <= scan_nxt;
            an_n     <= ~(NUM_DIG'(1) << scan_nxt);
         end
         seg_bcd <= digit[shown_idx];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIG-1:0] lz_vec;

   always_comb begin
      lz_vec = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lz_vec[3*c + 1] = (digit[3*c + 1] == 4'd0) && (digit[3*c + 2] == 4'd0);
         lz_vec[3*c + 2] = (digit[3*c + 2] == 4'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blank <= 1'b0;
      else        blank <= lz_vec[shown_idx];
   end
`else
   assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Bench for bcd_display_scheduler: value-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_bcd_display_scheduler;

   localparam int NUM_CH   = 2;
   localparam int SCAN_DIV = 4;
   localparam int ND       = 3 * NUM_CH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] val_flat;
   logic [1:0]  upd_req;
   logic [1:0]  upd_ack;
   logic [7:0]  conv_bin;
   logic [3:0]  conv_f, conv_s, conv_t;
   logic [5:0]  an_n;
   logic [3:0]  seg_bcd;
   logic        blank;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_display_scheduler #(.NUM_CH(NUM_CH), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .val_flat(val_flat), .upd_req(upd_req), .upd_ack(upd_ack),
      .conv_bin(conv_bin), .conv_f(conv_f), .conv_s(conv_s), .conv_t(conv_t),
      .an_n(an_n), .seg_bcd(seg_bcd), .blank(blank)
   );

   // Behavioural binary-to-BCD converter
   always_comb begin
      conv_f = 4'(conv_bin / 100);
      conv_s = 4'((conv_bin / 10) % 10);
      conv_t = 4'(conv_bin % 10);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: captured value per channel, scan derived from edge count since reset
   int         m_edges = 0;
   int         m_busy  = 0;
   int         m_last  = NUM_CH - 1;
   int         m_g     = 0;
   int         m_cv    = 0;
   int         m_val [NUM_CH];
   logic [1:0] m_pend  = '0;
   logic [7:0] m_conv  = '0;
   logic [1:0] m_ack   = '0;
   logic [5:0] m_an    = '1;
   logic [3:0] m_seg   = '0;
   logic       m_blank = 1'b0;

   function automatic int dig_of(input int i);
      int v;
      v = m_val[i / 3];
      case (i % 3)
         0:       return v % 10;
         1:       return (v / 10) % 10;
         default: return v / 100;
      endcase
   endfunction

   function automatic logic blank_of(input int i);
      int v;
      v = m_val[i / 3];
      case (i % 3)
         0:       return 1'b0;
         1:       return (v < 10);
         default: return (v < 100);
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edges = 0; m_busy = 0; m_last = NUM_CH - 1; m_g = 0; m_cv = 0;
         for (int i = 0; i < NUM_CH; i++) m_val[i] = 0;
         m_pend = '0; m_conv = '0; m_ack = '0; m_an = '1; m_seg = '0; m_blank = 1'b0;
      end else begin
         int         idx;
         int         c;
         logic       found;
         logic [1:0] req_all;
         logic [1:0] clr;
         m_edges++;
         idx = (m_edges / SCAN_DIV) % ND;
         if (m_edges >= SCAN_DIV) m_an = ~(6'b1 << idx);
         m_seg = 4'(dig_of(idx));
`ifdef LEADING_ZERO_BLANK_EN
         m_blank = blank_of(idx);
`else
         m_blank = 1'b0;
`endif
         m_ack = '0;
         clr   = '0;
         if (m_busy == 0) begin
            req_all = m_pend | upd_req;
            found   = 1'b0;
            for (int k = 1; k <= NUM_CH; k++) begin
               c = (m_last + k) % NUM_CH;
               if (!found && req_all[c]) begin
                  found = 1'b1;
                  m_g   = c;
               end
            end
            if (found) begin
               m_last = m_g;
               m_cv   = int'(val_flat[8*m_g +: 8]);
               m_conv = 8'(m_cv);
               m_busy = 2;
            end
         end else begin
            m_busy--;
            if (m_busy == 0) begin
               m_val[m_g] = m_cv;
               m_ack[m_g] = 1'b1;
               clr[m_g]   = 1'b1;
            end
         end
         m_pend = (m_pend & ~clr) | upd_req;
      end
   end

   always @(negedge clk) begin
      check("upd_ack", upd_ack, m_ack);
      check("conv_bin", conv_bin, m_conv);
      check("an_n", an_n, m_an);
      check("seg_bcd", seg_bcd, m_seg);
      check("blank", blank, m_blank);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic wait_an(input logic [5:0] pat, input string name);
      int n;
      n = 0;
      while (an_n !== pat && n < 60) begin
         step(1);
         n++;
      end
      check({name, "_an"}, an_n, pat);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   logic [1:0] acks [1:7];
   logic [1:0] ack_seen;
   int         n;

   initial begin
      val_flat = '0;
      upd_req  = '0;
      rst_n    = 1'b0;
      step(5);
      check("rst_an_n", an_n, 6'h3f);
      check("rst_ack", upd_ack, 2'b00);
      check("rst_conv", conv_bin, 8'd0);
      rst_n = 1'b1;
      wait_an(6'b111110, "t1_d0");
      check("t1_seg_d0", seg_bcd, 4'd0);
      wait_an(6'b011111, "t1_d5");
      check("t1_seg_d5", seg_bcd, 4'd0);

      // ch0 = 255
      val_flat[7:0] = 8'd255;
      upd_req = 2'b01;
      step(1);
      upd_req = 2'b00;
      check("t2_conv_n1", conv_bin, 8'd255);
      check("t2_ack_n1", upd_ack, 2'b00);
      step(1);
      check("t2_conv_n2", conv_bin, 8'd255);
      check("t2_ack_n2", upd_ack, 2'b00);
      step(1);
      check("t2_ack_n3", upd_ack, 2'b01);
      step(1);
      check("t2_ack_n4", upd_ack, 2'b00);
      wait_an(6'b111110, "t2_d0");
      check("t2_ones", seg_bcd, 4'd5);
      wait_an(6'b111101, "t2_d1");
      check("t2_tens", seg_bcd, 4'd5);
      wait_an(6'b111011, "t2_d2");
      check("t2_hund", seg_bcd, 4'd2);

      // round robin: ch0=123, ch1=45
      do_reset();
      val_flat = {8'd45, 8'd123};
      for (int r = 0; r < 2; r++) begin
         upd_req = 2'b11;
         for (int s = 1; s <= 7; s++) begin
            step(1);
            upd_req = 2'b00;
            acks[s] = upd_ack;
         end
         check("t3_ack_n3", acks[3], 2'b01);
         check("t3_ack_n4", acks[4], 2'b00);
         check("t3_ack_n6", acks[6], 2'b10);
         check("t3_ack_n7", acks[7], 2'b00);
      end
      wait_an(6'b110111, "t3_d3");
      check("t3_ch1_ones", seg_bcd, 4'd5);
      wait_an(6'b011111, "t3_d5");
      check("t3_ch1_hund", seg_bcd, 4'd0);
      wait_an(6'b111011, "t3_d2");
      check("t3_ch0_hund", seg_bcd, 4'd1);

      // scan period
      wait_an(6'b111110, "t4_start");
      n = 0;
      while (an_n === 6'b111110 && n < 100) begin step(1); n++; end
      while (an_n !== 6'b111110 && n < 100) begin step(1); n++; end
      check("t4_period", n, 24);

      // request arriving during capture of the same channel is served again
      do_reset();
      val_flat[7:0] = 8'd10;
      upd_req = 2'b01;
      step(1);
      upd_req = 2'b00;
      step(1);
      val_flat[7:0] = 8'd20;
      upd_req = 2'b01;
      acks[1] = 2'b00; acks[2] = 2'b00;
      for (int s = 3; s <= 7; s++) begin
         step(1);
         upd_req = 2'b00;
         acks[s] = upd_ack;
      end
      check("t7_ack_n3", acks[3], 2'b01);
      check("t7_ack_n5", acks[5], 2'b00);
      check("t7_ack_n6", acks[6], 2'b01);
      step(2);
      wait_an(6'b111101, "t7_d1");
      check("t7_tens", seg_bcd, 4'd2);

      // reset in DRIVE aborts the conversion
      do_reset();
      val_flat[7:0] = 8'd77;
      upd_req = 2'b01;
      step(1);
      upd_req = 2'b00;
      check("t6_conv_drive", conv_bin, 8'd77);
      rst_n = 1'b0;
      step(1);
      check("t6_rst_an", an_n, 6'h3f);
      check("t6_rst_conv", conv_bin, 8'd0);
      rst_n = 1'b1;
      ack_seen = '0;
      for (int s = 0; s < 8; s++) begin
         step(1);
         ack_seen = ack_seen | upd_ack;
      end
      check("t6_no_ack", ack_seen, 2'b00);
      check("t6_conv_idle", conv_bin, 8'd0);
      wait_an(6'b111110, "t6_d0");
      check("t6_ones", seg_bcd, 4'd0);

`ifdef LEADING_ZERO_BLANK_EN
      do_reset();
      val_flat[7:0] = 8'd7;
      upd_req = 2'b01;
      step(1);
      upd_req = 2'b00;
      step(4);
      wait_an(6'b111110, "t5a_d0");
      check("t5a_ones", seg_bcd, 4'd7);
      check("t5a_ones_blank", blank, 1'b0);
      wait_an(6'b111101, "t5a_d1");
      check("t5a_tens_blank", blank, 1'b1);
      wait_an(6'b111011, "t5a_d2");
      check("t5a_hund_blank", blank, 1'b1);
      val_flat[7:0] = 8'd0;
      upd_req = 2'b01;
      step(1);
      upd_req = 2'b00;
      step(4);
      wait_an(6'b111110, "t5b_d0");
      check("t5b_ones", seg_bcd, 4'd0);
      check("t5b_ones_blank", blank, 1'b0);
      val_flat[7:0] = 8'd105;
      upd_req = 2'b01;
      step(1);
      upd_req = 2'b00;
      step(4);
      wait_an(6'b111101, "t5c_d1");
      check("t5c_tens", seg_bcd, 4'd0);
      check("t5c_tens_blank", blank, 1'b0);
      wait_an(6'b111011, "t5c_d2");
      check("t5c_hund", seg_bcd, 4'd1);
      check("t5c_hund_blank", blank, 1'b0);
`endif

      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
